// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arms on command, waits for a trigger edge, forwards cfg_len samples as one AXIS packet.
// Optional forced trigger after AUTO_SAMPLES discarded samples when ADC_CAP_AUTOTRIG_EN is defined.
module adc_capture_ctrl #(
    parameter int DATA_W       = 8,
    parameter int LEN_W        = 16,
    parameter int AUTO_SAMPLES = 65535
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_trig_sel,
    input  logic              cfg_trig_fall,
    input  logic [1:0]        trig_in,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              auto_trig
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       sync0, sync1, prev, rise_q, fall_q;
    logic [LEN_W-1:0] len_q, cnt;
    logic             sel_q, fall_sel_q, aborting;
    logic             trig_hit, arm_ok, drain, room, take, auto_fire;

    assign s_axis_tready = 1'b1;
    assign busy     = (state == ARMED) || (state == CAPTURE) || m_axis_tvalid;
    assign trig_hit = fall_sel_q ? fall_q[sel_q] : rise_q[sel_q];
    assign arm_ok   = cfg_arm && !cfg_abort && (cfg_len != '0) && (state == IDLE || state == DONE);
    assign drain    = m_axis_tvalid && m_axis_tready;
    assign room     = !m_axis_tvalid || m_axis_tready;
    // Once all len samples are in, later samples are simply discarded rather than counted as drops.
    assign take     = (state == CAPTURE) && !aborting && !cfg_abort && s_axis_tvalid && (cnt != len_q);

`ifdef ADC_CAP_AUTOTRIG_EN
    localparam int AW = $clog2(AUTO_SAMPLES + 1);
    logic [AW-1:0] auto_cnt;
    logic          auto_q;

    assign auto_fire = (state == ARMED) && !cfg_abort && s_axis_tvalid &&
                       (auto_cnt == AW'(AUTO_SAMPLES - 1));
    assign auto_trig = auto_q;

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            auto_cnt <= '0;
            auto_q   <= 1'b0;
        end else if (arm_ok) begin
            auto_cnt <= '0;
            auto_q   <= 1'b0;
        end else begin
            if (state == ARMED && s_axis_tvalid)
                auto_cnt <= auto_cnt + 1'b1;
            if (auto_fire && !trig_hit)
                auto_q <= 1'b1;
        end
    end
`else
    assign auto_fire = 1'b0;
    assign auto_trig = 1'b0;
`endif

    // 2-FF synchronizer, then a previous-value register; edges are registered so they land 3 cycles after the pin.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            sync0  <= '0;
            sync1  <= '0;
            prev   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync0  <= trig_in;
            sync1  <= sync0;
            prev   <= sync1;
            rise_q <= sync1 & ~prev;
            fall_q <= ~sync1 & prev;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (cfg_abort)   state_nxt = IDLE;
                else if (arm_ok) state_nxt = ARMED;
            end
            ARMED: begin
                if (cfg_abort)                  state_nxt = IDLE;
                else if (trig_hit || auto_fire) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (aborting) begin
                    if (drain) state_nxt = IDLE;
                end else if (cfg_abort) begin
                    if (room) state_nxt = IDLE;
                end else if (drain && m_axis_tlast) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            cnt           <= '0;
            len_q         <= '0;
            sel_q         <= 1'b0;
            fall_sel_q    <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            aborting      <= 1'b0;
        end else begin
            if (arm_ok) begin
                len_q      <= cfg_len;
                sel_q      <= cfg_trig_sel;
                fall_sel_q <= cfg_trig_fall;
                cnt        <= '0;
                done       <= 1'b0;
                overflow   <= 1'b0;
            end
            if (cfg_abort)
                done <= 1'b0;

            if (take && room) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= (cnt == len_q - 1'b1);
                cnt           <= cnt + 1'b1;
            end else if (drain) begin
                m_axis_tvalid <= 1'b0;
            end
            if (take && !room)
                overflow <= 1'b1;

            // Abort with a stalled beat: close the packet on that beat and wait for the sink.
            if (state == CAPTURE && !aborting && cfg_abort && m_axis_tvalid && !m_axis_tready) begin
                aborting     <= 1'b1;
                m_axis_tlast <= 1'b1;
            end
            if (aborting && drain)
                aborting <= 1'b0;
            if (state == CAPTURE && !aborting && !cfg_abort && drain && m_axis_tlast)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed table, hand-written corner sequences, randomized traffic vs a queue-based model.
module tb_adc_capture_ctrl;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;
    localparam int AUTO   = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_arm, cfg_abort, cfg_trig_sel, cfg_trig_fall;
    logic [LEN_W-1:0]  cfg_len;
    logic [1:0]        trig_in;
    logic              s_axis_tvalid, s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              busy, done, overflow, auto_trig;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .AUTO_SAMPLES(AUTO)) dut (
        .axis_aclk(clk), .axis_aresetn(rstn),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_len(cfg_len),
        .cfg_trig_sel(cfg_trig_sel), .cfg_trig_fall(cfg_trig_fall), .trig_in(trig_in),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .overflow(overflow), .auto_trig(auto_trig)
    );

    int n_vec = 0, n_bad = 0, dut_beats = 0;

    // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 finished; output holder is a 1-deep queue.
    typedef struct { logic [DATA_W-1:0] d; bit last; } beat_t;
    beat_t      q[$];
    int         ph, m_len, m_cnt, m_acnt;
    bit         m_sel, m_fall, m_done, m_ovf, m_auto, m_abt;
    logic [1:0] h [4];

    typedef struct {
        bit arm, abort; logic [LEN_W-1:0] len; logic [1:0] trig; bit rdy;
        bit ev; logic [DATA_W-1:0] ed; bit el, eb, edn;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ph = 0; m_len = 0; m_cnt = 0; m_acnt = 0;
        m_sel = 0; m_fall = 0; m_done = 0; m_ovf = 0; m_auto = 0; m_abt = 0;
        for (int i = 0; i < 4; i++) h[i] = 2'b00;
    endtask

    task automatic model_step();
        bit hit, drn, last_out, arm_ok, autof;
        hit    = m_fall ? (h[3][m_sel] & ~h[2][m_sel]) : (h[2][m_sel] & ~h[3][m_sel]);
        drn    = (q.size() > 0) && m_axis_tready;
        arm_ok = cfg_arm && !cfg_abort && (cfg_len != 0) && (ph == 0 || ph == 3);
        autof  = 0;
        case (ph)
            0, 3: begin
                if (cfg_abort) begin ph = 0; m_done = 0; end
                else if (arm_ok) begin
                    ph = 1; m_len = int'(cfg_len); m_sel = cfg_trig_sel; m_fall = cfg_trig_fall;
                    m_cnt = 0; m_acnt = 0; m_done = 0; m_ovf = 0; m_auto = 0;
                end
            end
            1: begin
                if (cfg_abort) begin ph = 0; m_done = 0; end
                else begin
`ifdef ADC_CAP_AUTOTRIG_EN
                    if (s_axis_tvalid) begin m_acnt++; if (m_acnt == AUTO) autof = 1; end
`endif
                    if (hit) ph = 2;
                    else if (autof) begin ph = 2; m_auto = 1; end
                end
            end
            default: begin
                if (m_abt) begin
                    if (drn) begin void'(q.pop_front()); ph = 0; m_abt = 0; end
                end else if (cfg_abort) begin
                    m_done = 0;
                    if (q.size() > 0 && !m_axis_tready) begin q[0].last = 1; m_abt = 1; end
                    else begin if (drn) void'(q.pop_front()); ph = 0; end
                end else begin
                    last_out = drn ? q[0].last : 1'b0;
                    if (drn) void'(q.pop_front());
                    if (s_axis_tvalid && m_cnt < m_len) begin
                        if (q.size() == 0) begin
                            q.push_back('{s_axis_tdata, (m_cnt == m_len - 1)});
                            m_cnt++;
                        end else m_ovf = 1;
                    end
                    if (last_out) begin ph = 3; m_done = 1; end
                end
            end
        endcase
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = trig_in;
    endtask

    // One clock: advance model with the applied inputs, then compare registered outputs after the edge.
    task automatic cyc();
        model_step();
        if (m_axis_tvalid && m_axis_tready) dut_beats++;
        @(posedge clk); #1;
        chk("tvalid", m_axis_tvalid, (q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata", m_axis_tdata, q[0].d);
            chk("tlast", m_axis_tlast, q[0].last);
        end
        chk("busy", busy, (ph == 1 || ph == 2 || q.size() > 0));
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("auto_trig", auto_trig, m_auto);
        chk("s_tready", s_axis_tready, 1'b1);
    endtask

    task automatic quiet();
        cfg_arm = 0; cfg_abort = 0; s_axis_tvalid = 0; m_axis_tready = 1;
    endtask

    task automatic do_reset();
        rstn = 0; quiet();
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_auto", auto_trig, 0);
        chk("rst_tready", s_axis_tready, 1);
        rstn = 1;
    endtask

    task automatic arm(input int len, input bit sel, input bit fall);
        cfg_arm = 1; cfg_len = LEN_W'(len); cfg_trig_sel = sel; cfg_trig_fall = fall;
        cyc();
        cfg_arm = 0; dut_beats = 0;
    endtask

    initial begin
        logic [DATA_W-1:0] hd;
        logic              hl;
        cfg_len = 0; cfg_trig_sel = 0; cfg_trig_fall = 0; trig_in = 0; s_axis_tdata = 0;
        quiet();
        do_reset();

        // Capture len=4 on rising trig_in[0], then len=0 / abort / arm+abort handling.
        tbl[0]  = '{1, 0, 4, 2'b00, 1, 0, 8'h00, 0, 1, 0};
        for (int i = 1; i <= 4; i++) tbl[i] = '{0, 0, 4, 2'b01, 1, 0, 8'h00, 0, 1, 0};
        tbl[5]  = '{0, 0, 4, 2'b01, 1, 1, 8'h15, 0, 1, 0};
        tbl[6]  = '{0, 0, 4, 2'b01, 1, 1, 8'h16, 0, 1, 0};
        tbl[7]  = '{0, 0, 4, 2'b01, 1, 1, 8'h17, 0, 1, 0};
        tbl[8]  = '{0, 0, 4, 2'b01, 1, 1, 8'h18, 1, 1, 0};
        tbl[9]  = '{0, 0, 4, 2'b01, 1, 0, 8'h00, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 2'b01, 1, 0, 8'h00, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 2'b01, 1, 0, 8'h00, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 2'b01, 1, 0, 8'h00, 0, 0, 0};
        tbl[13] = '{1, 1, 4, 2'b01, 1, 0, 8'h00, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            cfg_arm = tbl[i].arm; cfg_abort = tbl[i].abort; cfg_len = tbl[i].len;
            cfg_trig_sel = 0; cfg_trig_fall = 0; trig_in = tbl[i].trig;
            s_axis_tvalid = 1; s_axis_tdata = DATA_W'(8'h10 + i); m_axis_tready = tbl[i].rdy;
            cyc();
            chk($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].ed);
                chk($sformatf("tbl%0d_tlast", i), m_axis_tlast, tbl[i].el);
            end
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].edn);
        end
        quiet();

        // Falling-edge select: a rising edge is ignored, the following falling edge starts capture.
        trig_in = 2'b00;
        repeat (5) cyc();
        arm(4, 0, 1);
        trig_in = 2'b01;
        repeat (7) cyc();
        chk("fall_no_beats", dut_beats, 0);
        chk("fall_still_armed", busy, 1);
        trig_in = 2'b00; s_axis_tvalid = 1;
        for (int i = 0; i < 14; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        chk("fall_beats", dut_beats, 4);
        chk("fall_done", done, 1);

        // len=8 with a 3-cycle sink stall: overflow, held beat, still exactly 8 beats.
        arm(8, 1, 0);
        trig_in = 2'b10;
        for (int i = 0; i < 20 && dut_beats < 2; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        chk("stall_started", (dut_beats >= 2), 1);
        m_axis_tready = 0; s_axis_tdata = DATA_W'($urandom); cyc();
        hd = m_axis_tdata; hl = m_axis_tlast;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = DATA_W'($urandom); cyc();
            chk("stall_tdata_hold", m_axis_tdata, hd);
            chk("stall_tlast_hold", m_axis_tlast, hl);
            chk("stall_tvalid_hold", m_axis_tvalid, 1);
        end
        m_axis_tready = 1;
        for (int i = 0; i < 30 && !done; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        chk("stall_beats", dut_beats, 8);
        chk("stall_ovf", overflow, 1);
        chk("stall_done", done, 1);

        // Abort with a stalled pending beat: tlast forced, held until handshake, then idle.
        arm(6, 0, 0);
        trig_in = 2'b11;
        for (int i = 0; i < 20 && !m_axis_tvalid; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        chk("abort_beat_pending", m_axis_tvalid, 1);
        m_axis_tready = 0; cfg_abort = 1; cyc();
        cfg_abort = 0; cyc();
        chk("abort_tvalid_held", m_axis_tvalid, 1);
        chk("abort_tlast_forced", m_axis_tlast, 1);
        m_axis_tready = 1; cyc();
        chk("abort_tvalid_gone", m_axis_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);

        // Reset in the middle of a packet drops the pending beat.
        arm(5, 1, 1);
        trig_in = 2'b01;
        for (int i = 0; i < 20 && !m_axis_tvalid; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        m_axis_tready = 0; s_axis_tdata = DATA_W'($urandom); cyc();
        do_reset();
        trig_in = 2'b00; s_axis_tvalid = 0;
        repeat (5) cyc();

`ifdef ADC_CAP_AUTOTRIG_EN
        arm(3, 0, 0);
        s_axis_tvalid = 1;
        for (int i = 0; i < 12; i++) begin s_axis_tdata = DATA_W'($urandom); cyc(); end
        chk("auto_set", auto_trig, 1);
        chk("auto_done", done, 1);
        s_axis_tvalid = 0;
        arm(3, 0, 0);
        chk("auto_cleared", auto_trig, 0);
        cfg_abort = 1; cyc(); cfg_abort = 0;
`endif

        // Randomized traffic: random lengths, edges, source gaps, backpressure, stray arm/abort.
        for (int p = 0; p < 25; p++) begin
            arm($urandom_range(1, 10), 1'($urandom), 1'($urandom));
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 7) == 0) trig_in[$urandom_range(0, 1)] ^= 1'b1;
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                s_axis_tdata  = DATA_W'($urandom);
                m_axis_tready = ($urandom_range(0, 2) != 0);
                cfg_abort     = ($urandom_range(0, 49) == 0);
                cfg_arm       = ($urandom_range(0, 29) == 0);
                cfg_len       = LEN_W'($urandom_range(0, 10));
                cyc();
            end
            quiet();
            for (int i = 0; i < 10 && m_axis_tvalid; i++) cyc();
            cfg_abort = 1; cyc(); cfg_abort = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
